// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer engine: FSM encoding, default
// SPI mode constants and a constant-evaluable ceil(log2) helper.
package spi_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Default SPI mode 0
    localparam int unsigned SPI_CPOL_DEF = 0;
    localparam int unsigned SPI_CPHA_DEF = 0;

    // Number of bits needed to hold values 0..value-1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCK timing generator: HALF-period divider, SCK edge counter and the
// leading/trailing edge strobes consumed by the transfer FSM.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned HALF   = 5
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr_i,
    input  logic run_i,
    input  logic edge_en_i,
    output logic tick_c_o,
    output logic lead_edge_c_o,
    output logic trail_edge_c_o,
    output logic last_edge_c_o
);

    localparam int unsigned HALF_W = clog2(HALF);
    localparam int unsigned EDGE_W = clog2(2 * DATA_W + 1);
    localparam logic [HALF_W-1:0] HALF_MAX  = HALF_W'(HALF - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [HALF_W-1:0] half_q, half_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    // The accept cycle counts as the first divider tick, hence the load of 1
    assign tick_c_o       = run_i && (half_q == HALF_MAX);
    assign lead_edge_c_o  = tick_c_o && edge_en_i && !edge_q[0];
    assign trail_edge_c_o = tick_c_o && edge_en_i && edge_q[0];
    assign last_edge_c_o  = (edge_q == EDGE_LAST);

    // Divider and edge counter next-state
    always_comb begin
        half_d = half_q;
        edge_d = edge_q;
        if (clr_i) begin
            half_d = HALF_W'(1);
            edge_d = '0;
        end else if (run_i) begin
            half_d = tick_c_o ? '0 : half_q + HALF_W'(1);
            if (tick_c_o && edge_en_i) begin
                edge_d = edge_q + EDGE_W'(1);
            end
        end else begin
            half_d = '0;
        end
    end

    // Counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            half_q <= '0;
            edge_q <= '0;
        end else begin
            half_q <= half_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// Full-duplex SPI master shift engine. Shifts tx_data out on spi_mosi while
// capturing spi_miso into rx_data. Optional macro SPI_CS_CTRL_EN adds the
// spi_cs_n output and a SETUP phase of one SCK half-period before the first edge.
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned HALF      = 5,
    parameter int unsigned CPOL      = SPI_CPOL_DEF,
    parameter int unsigned CPHA      = SPI_CPHA_DEF,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
`ifdef SPI_CS_CTRL_EN
    ,
    output logic              spi_cs_n
`endif
);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
`ifdef SPI_CS_CTRL_EN
    logic              cs_n_q, cs_n_d;
`endif

    logic accept_c, run_c, edge_en_c;
    logic tick_c, lead_c, trail_c, last_c;
    logic present_c, sample_c;

    // Bit presented on the wire for the current bit order
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    // Drop the presented bit
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    assign accept_c  = (state_q == ST_IDLE) && start;
    assign run_c     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign edge_en_c = (state_q == ST_SHIFT);

    // CPHA=0 presents on trailing edges (never after the final one); CPHA=1 on leading
    assign present_c = (CPHA == 0) ? (trail_c && !last_c) : lead_c;
    assign sample_c  = (CPHA == 0) ? lead_c : trail_c;

    spi_sclk_gen #(
        .DATA_W (DATA_W),
        .HALF   (HALF)
    ) u_sclk_gen (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .clr_i          (accept_c),
        .run_i          (run_c),
        .edge_en_i      (edge_en_c),
        .tick_c_o       (tick_c),
        .lead_edge_c_o  (lead_c),
        .trail_edge_c_o (trail_c),
        .last_edge_c_o  (last_c)
    );

    // Transfer FSM, shift registers and pin drivers: next-state
    always_comb begin
        state_d = state_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
`ifdef SPI_CS_CTRL_EN
        cs_n_d  = cs_n_q;
`endif

        if (lead_c || trail_c) begin
            sclk_d = ~sclk_q;
        end
        if (present_c) begin
            mosi_d  = (CPHA == 0) ? head_bit(shift_out(tx_sh_q)) : head_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
        end
        if (sample_c) begin
            rx_sh_d = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], spi_miso}
                                       : {spi_miso, rx_sh_q[DATA_W-1:1]};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    busy_d  = 1'b1;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    mosi_d  = (CPHA == 0) ? head_bit(tx_data) : 1'b0;
`ifdef SPI_CS_CTRL_EN
                    cs_n_d  = 1'b0;
                    state_d = ST_SETUP;
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SETUP: begin
                if (tick_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (trail_c && last_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rx_d    = rx_sh_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
`ifdef SPI_CS_CTRL_EN
                cs_n_d  = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'(CPOL);
            mosi_q  <= 1'b0;
`ifdef SPI_CS_CTRL_EN
            cs_n_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
`ifdef SPI_CS_CTRL_EN
            cs_n_q  <= cs_n_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
`ifdef SPI_CS_CTRL_EN
    assign spi_cs_n = cs_n_q;
`endif

endmodule
